// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_unit
// Purpose  : Fetch stage. Holds the fetch PC, issues single-outstanding word
//            reads over a req/gnt/rvalid handshake, buffers returned words
//            with their PC in a small FIFO and hands them to decode through
//            valid/ready. A redirect flushes the FIFO and kills any read that
//            is still in flight.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR  = '0,
    parameter int                    FIFO_DEPTH  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_req,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    input  logic                   imem_gnt,
    input  logic                   imem_rvalid,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0]  instr_pc
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [0:0] {
        S_REQ  = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   fetch_pc, fetch_pc_nxt;
    logic                    kill, kill_nxt;

    logic [INSTR_WIDTH-1:0]  fifo_instr [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]   fifo_pc    [FIFO_DEPTH];
    logic [PTR_W-1:0]        rd_ptr, wr_ptr;
    logic [CNT_W-1:0]        count;

    logic                    push;
    logic                    pop;
    logic [ADDR_WIDTH-1:0]   redirect_aligned;

    // Word-align the redirect target; the low two bits are discarded.
    assign redirect_aligned = redirect_pc & ~ADDR_WIDTH'(3);

    assign imem_addr   = fetch_pc;
    assign instr_valid = ~rst & (count != '0) & ~redirect_valid;
    assign pop         = instr_valid & instr_ready;
    assign instr       = fifo_instr[rd_ptr];
    assign instr_pc    = fifo_pc[rd_ptr];

    // Fetch state register: PC, FSM state and the kill flag for a stale read.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_REQ;
            fetch_pc <= RESET_ADDR;
            kill     <= 1'b0;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            kill     <= kill_nxt;
        end
    end

    // Next-state, request and push decode; redirect overrides the PC and arms kill.
    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        kill_nxt     = kill;
        imem_req     = 1'b0;
        push         = 1'b0;
        case (state)
            S_REQ: begin
                imem_req = ~rst & (count < CNT_W'(FIFO_DEPTH)) & ~redirect_valid;
                if (imem_req && imem_gnt) begin
                    fetch_pc_nxt = fetch_pc + ADDR_WIDTH'(4);
                    state_nxt    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    push      = ~kill & ~redirect_valid;
                    kill_nxt  = 1'b0;
                    state_nxt = S_REQ;
                end
            end
            default: state_nxt = S_REQ;
        endcase
        if (redirect_valid) begin
            fetch_pc_nxt = redirect_aligned;
            if (state == S_WAIT && !imem_rvalid) begin
                kill_nxt = 1'b1;
            end
        end
    end

    // FIFO pointers and occupancy; a redirect empties the buffer outright.
    always_ff @(posedge clk) begin
        if (rst || redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (!push && pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // FIFO storage; the PC of the returned word is one step behind fetch_pc.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr[wr_ptr] <= imem_rdata;
            fifo_pc[wr_ptr]    <= fetch_pc - ADDR_WIDTH'(4);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_fetch_unit
// Purpose  : Randomised bench for instruction_fetch_unit. A memory model
//            answers granted reads after a random latency; the expected
//            instruction stream is kept as a queue of words that have
//            arrived and not been flushed, and a monitor pops and compares
//            every handoff to decode.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_unit;

    localparam logic [31:0] RESET_ADDR = 32'h0000_0000;
    localparam int          FIFO_DEPTH = 2;
    localparam int          NCYC       = 4000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } item_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    int    tests = 0;
    int    fails = 0;
    int    delivered = 0;
    bit    done = 1'b0;
    item_t exp_q[$];

    instruction_fetch_unit #(
        .ADDR_WIDTH (32),
        .INSTR_WIDTH(32),
        .RESET_ADDR (RESET_ADDR),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .instr_pc      (instr_pc)
    );

    always #5 clk = ~clk;

    // Contents of instruction memory: a fixed scramble of the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    // Stimulus and memory model: decides inputs before each rising edge and
    // tracks the architectural fetch address and the set of live words.
    initial begin : stimulus
        logic [31:0] exp_fetch;
        logic [31:0] paddr;
        logic [31:0] tgt;
        int          cnt;
        bit          pending, live, staged, rv, redir, g, rs, was_pending, exp_req;
        item_t       staged_item;
        int          ready_pct, gnt_pct, redir_pct, phase;

        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
        exp_fetch = RESET_ADDR; pending = 0; live = 0; staged = 0; cnt = 0; paddr = '0;
        staged_item.pc = '0; staged_item.data = '0;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            phase = (cyc / 500) % 4;
            case (phase)
                0:       begin ready_pct = 100; gnt_pct = 100; redir_pct = 0; end
                1:       begin ready_pct = 10;  gnt_pct = 70;  redir_pct = 3; end
                2:       begin ready_pct = 60;  gnt_pct = 20;  redir_pct = 8; end
                default: begin ready_pct = 80;  gnt_pct = 80;  redir_pct = 5; end
            endcase

            // A word returned last cycle now sits in the buffer.
            if (staged) begin
                exp_q.push_back(staged_item);
                staged = 0;
            end

            rs    = (cyc < 2) || ($urandom_range(0, 299) == 0);
            redir = !rs && ($urandom_range(0, 99) < redir_pct);
            tgt   = $urandom;
            rv    = 0;
            if (rs) pending = 0;
            was_pending = pending;
            if (pending) begin
                cnt--;
                if (cnt == 0) begin
                    rv      = 1;
                    pending = 0;
                end
            end

            rst            = rs;
            redirect_valid = redir;
            redirect_pc    = tgt;
            imem_rvalid    = rv;
            imem_rdata     = rv ? mem_word(paddr) : $urandom;
            instr_ready    = ($urandom_range(0, 99) < ready_pct);
            imem_gnt       = 1'b0;

            if (rv && live && !redir) begin
                staged_item.pc   = paddr;
                staged_item.data = mem_word(paddr);
                staged           = 1;
            end
            if (rv) live = 0;

            #1;
            check("imem_addr", imem_addr, exp_fetch);
            exp_req = !rs && !was_pending && !redir && (exp_q.size() < FIFO_DEPTH);
            check("imem_req", {31'b0, imem_req}, {31'b0, exp_req});

            g = ($urandom_range(0, 99) < gnt_pct);
            imem_gnt = g;
            if (imem_req && g) begin
                pending   = 1;
                cnt       = $urandom_range(1, 3);
                paddr     = imem_addr;
                live      = 1;
                exp_fetch = exp_fetch + 32'd4;
            end
            if (redir) begin
                exp_q.delete();
                live      = 0;
                exp_fetch = {tgt[31:2], 2'b00};
            end
            if (rs) begin
                exp_q.delete();
                live      = 0;
                staged    = 0;
                exp_fetch = RESET_ADDR;
            end
        end

        @(negedge clk);
        done = 1'b1;
        #5;
        tests++;
        if (delivered < 100) begin
            fails++;
            $display("FAIL progress: got %0d deliveries, expected at least 100", delivered);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Monitor: checks the decode-side valid and pops/compares each handoff.
    initial begin : monitor
        item_t e;
        bit    exp_valid;
        while (!done) begin
            @(negedge clk);
            #2;
            if (done) break;
            exp_valid = !rst && !redirect_valid && (exp_q.size() > 0);
            check("instr_valid", {31'b0, instr_valid}, {31'b0, exp_valid});
            if (instr_valid && instr_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL underflow: got instr_pc 0x%08h, expected no delivery", instr_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("instr_pc", instr_pc, e.pc);
                    check("instr", instr, e.data);
                    delivered++;
                end
            end
        end
    end

endmodule
`default_nettype wire
